condicionador_botoes: RTL and testbench

- Input-conditioning stage directly upstream of the memory-game top level.
- Synchronizes, debounces and validates the raw `botoes[3:0]` and `jogar` pushbuttons before they reach the game.
- Delivers a clean one-hot button level, a one-cycle accepted-play pulse and a one-cycle start pulse.
- Presses of more than one button at once are filtered out and flagged, so the game's play detection only ever sees single, stable presses.

---
 rtl/condicionador_botoes.sv | 242 ++++++++++++++++++++++++
 tb/tb_condicionador_botoes.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Input-conditioning stage in front of the memory-game top level. Synchronizes,
// debounces and validates the raw pushbuttons so the game only ever sees single,
// stable presses:
//   - button path: 5-state FSM (OCIOSO, FILTRANDO, PRESSIONADO, SOLTANDO,
//     MULTIPLOS) that accepts one-hot presses and rejects multi-button presses;
//   - jogar path: independent 2-state debouncer (SOLTO, APERTADO) that emits
//     a start pulse on the accepted press.
//
// Parameters:
//   DEBOUNCE_CICLOS  consecutive stable cycles to accept a press/release (>= 2)
//   CONT_LARGURA     debounce counter width, 2**CONT_LARGURA > DEBOUNCE_CICLOS
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high reset
//   botoes_in[3:0] raw asynchronous button levels, active-high
//   jogar_in       raw asynchronous start button, active-high
//   botoes_out     debounced one-hot button level (to the game 'botoes')
//   jogada_valida  one-cycle pulse when a single-button press is accepted
//   jogar_out      one-cycle pulse on the debounced rising edge of jogar
//   multiplos      high while a multi-button press is being rejected
//   db_estado      button FSM state code for the 7-segment debug display
// -----------------------------------------------------------------------------

// Two-flop synchronizer for one raw input lane.
module condicionador_botoes_sync (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [1:0] sync_pipe;

   always_ff @(posedge clock) begin
      if (reset) sync_pipe <= 2'b00;
      else       sync_pipe <= {sync_pipe[0], d};
   end

   assign q = sync_pipe[1];
endmodule

module condicionador_botoes #(
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int CONT_LARGURA    = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes_in,
   input  logic       jogar_in,
   output logic [3:0] botoes_out,
   output logic       jogada_valida,
   output logic       jogar_out,
   output logic       multiplos,
   output logic [3:0] db_estado
);
   localparam int NUM_ENTRADAS = 5;
   localparam logic [CONT_LARGURA-1:0] CNT_MAX = CONT_LARGURA'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      FILTRANDO   = 3'd1,
      PRESSIONADO = 3'd2,
      SOLTANDO    = 3'd3,
      MULTIPLOS   = 3'd4
   } estado_t;

   typedef enum logic {
      SOLTO    = 1'b0,
      APERTADO = 1'b1
   } estado_jogar_t;

   // ---------------------------------------------------------------------------
   // Synchronizers: lanes 3..0 are the buttons, lane 4 is jogar
   // ---------------------------------------------------------------------------
   logic [NUM_ENTRADAS-1:0] brutos;
   logic [NUM_ENTRADAS-1:0] sinc;
   logic [3:0]              s;
   logic                    s_jogar;

   assign brutos = {jogar_in, botoes_in};

   generate
      for (genvar g = 0; g < NUM_ENTRADAS; g++) begin : g_sync
         condicionador_botoes_sync u_sync (
            .clock (clock),
            .reset (reset),
            .d     (brutos[g]),
            .q     (sinc[g])
         );
      end
   endgenerate

   assign s       = sinc[3:0];
   assign s_jogar = sinc[4];

   // ---------------------------------------------------------------------------
   // Button path
   // ---------------------------------------------------------------------------
   estado_t                 estado;
   logic [3:0]              cand;
   logic [CONT_LARGURA-1:0] cnt;
   logic                    cand_um_quente;

   // cand is never zero while filtering, so this is a pure one-hot test
   assign cand_um_quente = (cand != 4'b0000) && ((cand & (cand - 4'd1)) == 4'b0000);

   always_ff @(posedge clock) begin
      if (reset) begin
         estado        <= OCIOSO;
         cand          <= 4'b0000;
         cnt           <= '0;
         botoes_out    <= 4'b0000;
         jogada_valida <= 1'b0;
         multiplos     <= 1'b0;
      end else begin
         jogada_valida <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (s != 4'b0000) begin
                  cand   <= s;
                  cnt    <= '0;
                  estado <= FILTRANDO;
               end
            end

            FILTRANDO: begin
               if (s != cand) begin
                  // any change (bounce or extra button) restarts from idle
                  estado <= OCIOSO;
                  cnt    <= '0;
               end else if (cnt == CNT_MAX) begin
                  cnt <= '0;
                  if (cand_um_quente) begin
                     estado        <= PRESSIONADO;
                     botoes_out    <= cand;
                     jogada_valida <= 1'b1;
                  end else begin
                     estado    <= MULTIPLOS;
                     multiplos <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            PRESSIONADO: begin
               if (s != cand) begin
                  estado <= SOLTANDO;
                  cnt    <= '0;
               end
            end

            SOLTANDO: begin
               // botoes_out keeps cand until the release is confirmed
               if (s == cand) begin
                  estado <= PRESSIONADO;
               end else if (s == 4'b0000) begin
                  if (cnt == CNT_MAX) begin
                     estado     <= OCIOSO;
                     botoes_out <= 4'b0000;
                     cnt        <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end

            MULTIPLOS: begin
               if (s != 4'b0000) begin
                  cnt <= '0;
               end else if (cnt == CNT_MAX) begin
                  estado    <= OCIOSO;
                  multiplos <= 1'b0;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               estado     <= OCIOSO;
               cnt        <= '0;
               botoes_out <= 4'b0000;
               multiplos  <= 1'b0;
            end
         endcase
      end
   end

   assign db_estado = {1'b0, estado};

   // ---------------------------------------------------------------------------
   // Jogar path: level must hold DEBOUNCE_CICLOS cycles in either direction
   // ---------------------------------------------------------------------------
   estado_jogar_t           estado_jogar;
   logic [CONT_LARGURA-1:0] cnt_jogar;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_jogar <= SOLTO;
         cnt_jogar    <= '0;
         jogar_out    <= 1'b0;
      end else begin
         jogar_out <= 1'b0;
         case (estado_jogar)
            SOLTO: begin
               if (!s_jogar) begin
                  cnt_jogar <= '0;
               end else if (cnt_jogar == CNT_MAX) begin
                  estado_jogar <= APERTADO;
                  cnt_jogar    <= '0;
                  jogar_out    <= 1'b1;
               end else begin
                  cnt_jogar <= cnt_jogar + 1'b1;
               end
            end

            APERTADO: begin
               // release is debounced too, but emits nothing
               if (s_jogar) begin
                  cnt_jogar <= '0;
               end else if (cnt_jogar == CNT_MAX) begin
                  estado_jogar <= SOLTO;
                  cnt_jogar    <= '0;
               end else begin
                  cnt_jogar <= cnt_jogar + 1'b1;
               end
            end

            default: begin
               estado_jogar <= SOLTO;
               cnt_jogar    <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_condicionador_botoes.sv
// -----------------------------------------------------------------------------
// tb_condicionador_botoes
//
// Directed bench for condicionador_botoes with DEBOUNCE_CICLOS = 4. Inputs are
// driven and outputs sampled on the falling clock edge. Timing reference: an
// input applied at a falling edge is first sampled on the next rising edge;
// a clean press is then visible 7 falling edges after it was applied.
// -----------------------------------------------------------------------------
module tb_condicionador_botoes;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] botoes_in = 4'b0000;
   logic       jogar_in  = 1'b0;
   logic [3:0] botoes_out;
   logic       jogada_valida;
   logic       jogar_out;
   logic       multiplos;
   logic [3:0] db_estado;

   condicionador_botoes #(
      .DEBOUNCE_CICLOS (D),
      .CONT_LARGURA    (8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .botoes_in     (botoes_in),
      .jogar_in      (jogar_in),
      .botoes_out    (botoes_out),
      .jogada_valida (jogada_valida),
      .jogar_out     (jogar_out),
      .multiplos     (multiplos),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // pulse bookkeeping
   int   n_jv = 0;
   int   n_jo = 0;
   int   n_consec = 0;
   logic jv_prev = 1'b0;
   logic jo_prev = 1'b0;

   always @(negedge clock) begin
      if (jogada_valida) n_jv++;
      if (jogar_out) n_jo++;
      if (jogada_valida && jv_prev) n_consec++;
      if (jogar_out && jo_prev) n_consec++;
      jv_prev = jogada_valida;
      jo_prev = jogar_out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ciclos(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_jv;
      int base_jo;
      logic [3:0] bounce [10];

      // ---- reset with random inputs ----
      botoes_in = 4'($urandom);
      jogar_in  = 1'($urandom);
      ciclos(2);
      chk("rst_botoes_out", botoes_out, 0);
      chk("rst_jv", jogada_valida, 0);
      chk("rst_jogar_out", jogar_out, 0);
      chk("rst_multiplos", multiplos, 0);
      chk("rst_db_estado", db_estado, 0);
      reset = 1'b0;
      botoes_in = 4'b0000;
      jogar_in  = 1'b0;
      ciclos(1);
      chk("post_rst_jv", jogada_valida, 0);
      chk("post_rst_jogar_out", jogar_out, 0);
      ciclos(5);
      base_jv = n_jv;

      // ---- clean press 0100 ----
      botoes_in = 4'b0100;
      ciclos(6);
      chk("clean_before_out", botoes_out, 0);
      chk("clean_before_jv", jogada_valida, 0);
      chk("clean_filtrando", db_estado, 1);
      ciclos(1);
      chk("clean_out", botoes_out, 4'b0100);
      chk("clean_jv", jogada_valida, 1);
      chk("clean_db_estado", db_estado, 2);
      ciclos(1);
      chk("clean_jv_drop", jogada_valida, 0);
      chk("clean_out_hold", botoes_out, 4'b0100);
      botoes_in = 4'b0000;
      ciclos(10);
      chk("clean_rel_out", botoes_out, 0);
      chk("clean_rel_db", db_estado, 0);
      chk("clean_pulses", n_jv - base_jv, 1);

      // ---- bouncing press 0001 ----
      base_jv = n_jv;
      for (int i = 0; i < 10; i++) bounce[i] = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
      // last bounce phase is 0001 from index 8 onward: stable from there
      for (int i = 0; i < 10; i++) begin
         botoes_in = bounce[i];
         ciclos(1);
         chk("bounce_out", botoes_out, 0);
      end
      botoes_in = 4'b0001;
      ciclos(4);
      chk("bounce_before_jv", jogada_valida, 0);
      ciclos(1);
      chk("bounce_jv", jogada_valida, 1);
      chk("bounce_out_acc", botoes_out, 4'b0001);
      botoes_in = 4'b0000;
      ciclos(10);
      chk("bounce_pulses", n_jv - base_jv, 1);
      chk("bounce_rel_db", db_estado, 0);

      // ---- multi-button 0011 ----
      base_jv = n_jv;
      botoes_in = 4'b0011;
      ciclos(6);
      chk("multi_before", multiplos, 0);
      ciclos(1);
      chk("multi_flag", multiplos, 1);
      chk("multi_db", db_estado, 4);
      chk("multi_out", botoes_out, 0);
      ciclos(6);
      chk("multi_hold", db_estado, 4);
      botoes_in = 4'b0000;
      ciclos(5);
      chk("multi_rel_still", db_estado, 4);
      ciclos(1);
      chk("multi_rel_db", db_estado, 0);
      chk("multi_rel_flag", multiplos, 0);
      chk("multi_pulses", n_jv - base_jv, 0);
      ciclos(3);

      // ---- accepted 1000, dropout glitch, full release ----
      botoes_in = 4'b1000;
      ciclos(7);
      chk("drop_acc_out", botoes_out, 4'b1000);
      chk("drop_acc_jv", jogada_valida, 1);
      ciclos(2);
      base_jv = n_jv;
      botoes_in = 4'b0000;
      ciclos(1);
      botoes_in = 4'b1000;
      chk("drop_out_a", botoes_out, 4'b1000);
      ciclos(1);
      chk("drop_out_b", botoes_out, 4'b1000);
      ciclos(1);
      chk("drop_soltando", db_estado, 3);
      chk("drop_out_c", botoes_out, 4'b1000);
      ciclos(1);
      chk("drop_back", db_estado, 2);
      ciclos(4);
      chk("drop_out_d", botoes_out, 4'b1000);
      chk("drop_no_pulse", n_jv - base_jv, 0);
      botoes_in = 4'b0000;
      ciclos(10);
      chk("drop_rel_out", botoes_out, 0);
      chk("drop_rel_db", db_estado, 0);

      // ---- jogar together with 0010 ----
      base_jv = n_jv;
      base_jo = n_jo;
      botoes_in = 4'b0010;
      jogar_in  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ciclos(1);
         if (i == 4) chk("jogar_before", jogar_out, 0);
         if (i == 5) chk("jogar_pulse", jogar_out, 1);
         if (i == 6) begin
            chk("jogar_drop", jogar_out, 0);
            chk("both_jv", jogada_valida, 1);
            chk("both_out", botoes_out, 4'b0010);
         end
      end
      botoes_in = 4'b0000;
      jogar_in  = 1'b0;
      ciclos(15);
      chk("both_jo_count", n_jo - base_jo, 1);
      chk("both_jv_count", n_jv - base_jv, 1);

      // ---- reset mid-FILTRANDO ----
      base_jv = n_jv;
      botoes_in = 4'b0100;
      ciclos(4);
      chk("mid_filtrando", db_estado, 1);
      reset = 1'b1;
      ciclos(1);
      reset = 1'b0;
      chk("mid_rst_db", db_estado, 0);
      chk("mid_rst_out", botoes_out, 0);
      chk("mid_rst_jv", jogada_valida, 0);
      ciclos(6);
      chk("mid_before_jv", jogada_valida, 0);
      chk("mid_pre_count", n_jv - base_jv, 0);
      ciclos(1);
      chk("mid_jv", jogada_valida, 1);
      chk("mid_out", botoes_out, 4'b0100);
      botoes_in = 4'b0000;
      ciclos(10);
      chk("mid_rel_db", db_estado, 0);

      chk("no_consec_pulses", n_consec, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
